// File: rtl/div_share_pkg.sv
// Shared types for the divider-sharing controller: FSM state encoding and response error codes.
package div_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_DBZ = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, combinational: grants the first requester at or above (ptr+1) mod N.
// Zero latency; grants nothing while en is low.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    if (en) begin
      // Scan starts one past the last winner so it gets lowest priority.
      for (int k = 1; k <= N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!any && req[IW'(idx)]) begin
          any              = 1'b1;
          gnt[IW'(idx)]    = 1'b1;
          gnt_idx          = IW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one sequential divider among NUM_REQ valid/ready clients, one division in flight.
// Accept to rsp_valid is 3 cycles plus divider latency; response held until the owner's rsp_ready.
module div_share_ctrl
  import div_share_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_dividend,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_divisor,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [DATAWIDTH-1:0]           rsp_quotient,
  output logic [DATAWIDTH-1:0]           rsp_remainder,
  output logic [1:0]                     rsp_err,
  output logic                           busy,
  output logic                           div_en,
  output logic [DATAWIDTH-1:0]           div_dividend,
  output logic [DATAWIDTH-1:0]           div_divisor,
  input  logic                           div_ready,
  input  logic [DATAWIDTH-1:0]           div_quotient,
  input  logic [DATAWIDTH-1:0]           div_remainder,
  input  logic                           div_vld
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        id_q, id_d;
  logic [DATAWIDTH-1:0] dvd_q, dvd_d;
  logic [DATAWIDTH-1:0] dvs_q, dvs_d;
  logic [DATAWIDTH-1:0] quo_q, quo_d;
  logic [DATAWIDTH-1:0] rem_q, rem_d;
  logic [1:0]           err_q, err_d;
  logic [WW-1:0]        wdog_q, wdog_d;

  logic [NUM_REQ-1:0]   gnt;
  logic [PW-1:0]        gnt_idx;
  logic                 arb_any;
  logic [WW-1:0]        wdog_inc;
  logic                 wdog_expire;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (state_q == IDLE),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (arb_any)
  );

  // Saturating count; expiry fires on the edge the count would reach TIMEOUT-1.
  assign wdog_inc    = (&wdog_q) ? wdog_q : wdog_q + 1'b1;
  assign wdog_expire = (wdog_inc == WDOG_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    err_d     = err_q;
    wdog_d    = wdog_q;
    req_ready = '0;
    rsp_valid = '0;
    div_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready = gnt;
          id_d      = gnt_idx;
          dvd_d     = req_dividend[gnt_idx*DATAWIDTH +: DATAWIDTH];
          dvs_d     = req_divisor[gnt_idx*DATAWIDTH +: DATAWIDTH];
          wdog_d    = '0;
          if (dvs_d == '0) begin
            quo_d   = '1;
            rem_d   = dvd_d;
            err_d   = ERR_DBZ;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (div_ready) begin
          div_en  = 1'b1;
          wdog_d  = '0;
          state_d = WAIT;
        end else if (wdog_expire) begin
          quo_d   = '0;
          rem_d   = '0;
          err_d   = ERR_TMO;
          state_d = RESP;
        end else begin
          wdog_d  = wdog_inc;
        end
      end
      WAIT: begin
        if (div_vld) begin
          quo_d   = div_quotient;
          rem_d   = div_remainder;
          err_d   = ERR_OK;
          state_d = RESP;
        end else if (wdog_expire) begin
          quo_d   = '0;
          rem_d   = '0;
          err_d   = ERR_TMO;
          state_d = RESP;
        end else begin
          wdog_d  = wdog_inc;
        end
      end
      RESP: begin
        rsp_valid[id_q] = 1'b1;
        if (rsp_ready[id_q]) begin
          ptr_d   = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      err_q   <= ERR_OK;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign div_dividend  = dvd_q;
  assign div_divisor   = dvs_q;
  assign rsp_quotient  = quo_q;
  assign rsp_remainder = rem_q;
  assign rsp_err       = err_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with a behavioural divider of configurable latency.
module tb_div_share_ctrl;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_dividend = '0;
  logic [NR*DW-1:0] req_divisor = '0;
  logic [NR-1:0]    rsp_valid;
  logic [NR-1:0]    rsp_ready = '0;
  logic [DW-1:0]    rsp_quotient, rsp_remainder;
  logic [1:0]       rsp_err;
  logic             busy, div_en;
  logic [DW-1:0]    div_dividend, div_divisor;
  logic             div_ready = 1'b1;
  logic [DW-1:0]    div_quotient = '0;
  logic [DW-1:0]    div_remainder = '0;
  logic             div_vld = 1'b0;

  int lat = 10;
  bit never_vld = 1'b0;
  bit mdl_busy = 1'b0;
  int mdl_cnt = 0;
  int en_cnt = 0;
  int n_checks = 0;
  int n_err = 0;

  div_share_ctrl #(.DATAWIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_err       (rsp_err),
    .busy          (busy),
    .div_en        (div_en),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_ready     (div_ready),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .div_vld       (div_vld)
  );

  // Divider: result valid 'lat' edges after the edge that samples div_en; not reset by rst.
  always @(posedge clk) begin
    div_vld <= 1'b0;
    if (div_en && div_ready) begin
      mdl_busy      <= 1'b1;
      mdl_cnt       <= 1;
      div_quotient  <= div_dividend / div_divisor;
      div_remainder <= div_dividend % div_divisor;
    end else if (mdl_busy) begin
      if (mdl_cnt == lat) begin
        mdl_busy <= 1'b0;
        div_vld  <= !never_vld;
      end else begin
        mdl_cnt <= mdl_cnt + 1;
      end
    end
  end

  always @(posedge clk) if (div_en) en_cnt <= en_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_dividend[i*DW +: DW] = a;
    req_divisor[i*DW +: DW]  = b;
    req_valid[i]             = 1'b1;
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_div_en"}, 32'(div_en), 0);
    chk({tag, "_div_opnds"}, {16'h0, div_dividend, div_divisor}, 0);
    chk({tag, "_rsp_data"}, {14'h0, rsp_err, rsp_quotient, rsp_remainder}, 0);
    rst = 1'b0;
  endtask

  // Called at a negedge with requests already driven; returns cycles from accept cycle to rsp_valid.
  task automatic run_txn(input string tag, input logic [NR-1:0] exp_gnt, input logic [DW-1:0] eq,
                         input logic [DW-1:0] er, input logic [1:0] ee, input bit drop, output int n);
    int w;
    #1;
    w = 0;
    while (req_ready == '0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_gnt"}, 32'(req_ready), 32'(exp_gnt));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (drop && n == 1) req_valid = req_valid & ~exp_gnt;
    end while (rsp_valid == '0 && n < 300);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(exp_gnt));
    chk({tag, "_quo"}, 32'(rsp_quotient), 32'(eq));
    chk({tag, "_rem"}, 32'(rsp_remainder), 32'(er));
    chk({tag, "_err"}, 32'(rsp_err), 32'(ee));
    rsp_ready = '1;
    @(negedge clk);
    rsp_ready = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int e0;
    bit seen;

    apply_reset("rst0");

    // Basic division, latency 10
    set_req(1, 8'd100, 8'd7);
    run_txn("t1", 4'b0010, 8'd14, 8'd2, 2'b00, 1'b1, n);
    chk("t1_lat", 32'(n), 13);
    chk("t1_idle", 32'(busy), 0);

    // Divide by zero handled locally
    e0 = en_cnt;
    set_req(2, 8'd9, 8'd0);
    run_txn("dbz", 4'b0100, 8'hFF, 8'd9, 2'b01, 1'b1, n);
    chk("dbz_lat", 32'(n), 1);
    chk("dbz_no_en", 32'(en_cnt - e0), 0);

    // Watchdog: divider accepts but never answers
    never_vld = 1'b1;
    set_req(3, 8'd40, 8'd3);
    #1;
    chk("tmo_gnt", 32'(req_ready), 32'b1000);
    @(negedge clk);
    req_valid = '0;
    chk("tmo_en", 32'(div_en), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid == '0 && n < 300);
    chk("tmo_lat", 32'(n), TO);
    chk("tmo_rsp_valid", 32'(rsp_valid), 32'b1000);
    chk("tmo_data", {16'h0, rsp_quotient, rsp_remainder}, 0);
    chk("tmo_err", 32'(rsp_err), 2);
    rsp_ready = '1;
    @(negedge clk);
    rsp_ready = '0;
    never_vld = 1'b0;
    set_req(0, 8'd81, 8'd9);
    run_txn("post_tmo", 4'b0001, 8'd9, 8'd0, 2'b00, 1'b1, n);

    // Response backpressure with other requesters waiting
    set_req(0, 8'd30, 8'd4);
    #1;
    chk("bp_gnt", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid = '0;
    set_req(2, 8'd50, 8'd5);
    set_req(3, 8'd77, 8'd10);
    n = 0;
    while (rsp_valid == '0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    rsp_ready = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 32'b0001);
      chk("bp_hold_data", {16'h0, rsp_quotient, rsp_remainder}, 32'h0702);
      chk("bp_hold_rdy", 32'(req_ready), 0);
    end
    rsp_ready = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    rsp_ready = '0;
    chk("bp_done", 32'(rsp_valid), 0);

    // Round robin from pointer 0 with all requesters active
    apply_reset("rst1");
    set_req(0, 8'd200, 8'd9);
    set_req(1, 8'd255, 8'd16);
    set_req(2, 8'd50, 8'd5);
    set_req(3, 8'd77, 8'd10);
    run_txn("rr1", 4'b0010, 8'd15, 8'd15, 2'b00, 1'b0, n);
    run_txn("rr2", 4'b0100, 8'd10, 8'd0, 2'b00, 1'b0, n);
    run_txn("rr3", 4'b1000, 8'd7, 8'd7, 2'b00, 1'b0, n);
    run_txn("rr0", 4'b0001, 8'd22, 8'd2, 2'b00, 1'b0, n);
    run_txn("rr1b", 4'b0010, 8'd15, 8'd15, 2'b00, 1'b0, n);
    req_valid = '0;

    // Reset during WAIT; the late divider result must be ignored
    set_req(1, 8'd100, 8'd7);
    #1;
    chk("rw_gnt", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("rw_busy", 32'(busy), 1);
    apply_reset("rst2");
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid != '0 || busy) seen = 1'b1;
    end
    chk("rw_no_rsp", 32'(seen), 0);
    set_req(0, 8'd12, 8'd5);
    set_req(1, 8'd100, 8'd7);
    run_txn("rw_post", 4'b0010, 8'd14, 8'd2, 2'b00, 1'b1, n);
    req_valid = '0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
